// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared types for the fetch-sequencing controller
package if_fetch_ctrl_pkg;
  typedef enum logic [2:0] {PC_BP, PC_JUMP, PC_EXC, PC_ERET, PC_DRET} pc_sel_e;
  typedef enum logic [1:0] {EXC_PC_EXC, EXC_PC_IRQ, EXC_PC_DBD, EXC_PC_DBG_EXC} exc_pc_sel_e;
  typedef enum logic [2:0] {RESET, BOOT, FETCH, FLUSH, SLEEP, DEBUG} fetch_state_e;
  localparam int FLUSH_CNT_W = 3;
endpackage

// File: rtl/if_redirect_prio.sv
// if_redirect_prio: picks the single highest-priority fetch redirect among this cycle's events
module if_redirect_prio
  import if_fetch_ctrl_pkg::*;
(
  input  logic        debug_mode_i,
  input  logic        dbg_req_i,
  input  logic        exc_i,
  input  logic        irq_pending_i,
  input  logic        irq_en_i,
  input  logic        dret_i,
  input  logic        mret_i,
  input  logic        branch_i,
  output logic        take_o,
  output pc_sel_e     mux_o,
  output exc_pc_sel_e exc_sel_o,
  output logic        enter_dbg_o,
  output logic        exit_dbg_o,
  output logic        is_trap_o
);
  logic dbg, irq, dret;
  // debug entry and interrupts are masked in debug mode; dret is only meaningful there
  assign dbg         = dbg_req_i & ~debug_mode_i;
  assign irq         = irq_pending_i & irq_en_i & ~debug_mode_i;
  assign dret        = dret_i & debug_mode_i;
  assign is_trap_o   = dbg | exc_i | irq;
  assign take_o      = is_trap_o | dret | mret_i | branch_i;
  assign mux_o       = is_trap_o ? PC_EXC : dret ? PC_DRET : mret_i ? PC_ERET : PC_JUMP;
  assign exc_sel_o   = dbg ? EXC_PC_DBD : exc_i ? (debug_mode_i ? EXC_PC_DBG_EXC : EXC_PC_EXC) : EXC_PC_IRQ;
  assign enter_dbg_o = dbg;
  assign exit_dbg_o  = dret & ~is_trap_o;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: sequences boot, redirects, flush windows, sleep and debug for the IF stage
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        exc_i,
  input  logic        irq_pending_i,
  input  logic        irq_en_i,
  input  logic        mret_i,
  input  logic        dret_i,
  input  logic        dbg_req_i,
  input  logic        wfi_i,
  output pc_sel_e     pc_sel_mux_o,
  output exc_pc_sel_e exc_sel_o,
  output logic        pc_sel_o,
  output logic        pc_set_o,
  output logic        flush_o,
  output logic        debug_mode_o,
  output logic        trap_ack_o
);
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
    $error("FLUSH_CYCLES must be in 1..7");
  end
  localparam logic [FLUSH_CNT_W-1:0] CntLoad = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  fetch_state_e            state_q;
  logic [FLUSH_CNT_W-1:0]  cnt_q;
  logic                    take, enter_dbg, exit_dbg, is_trap, dbg_d, wake, redirect;
  pc_sel_e                 mux;
  exc_pc_sel_e             exc_sel;
  if_redirect_prio u_prio (
    .debug_mode_i (debug_mode_o),
    .dbg_req_i    (dbg_req_i),
    .exc_i        (exc_i),
    .irq_pending_i(irq_pending_i),
    .irq_en_i     (irq_en_i),
    .dret_i       (dret_i),
    .mret_i       (mret_i),
    .branch_i     (branch_i),
    .take_o       (take),
    .mux_o        (mux),
    .exc_sel_o    (exc_sel),
    .enter_dbg_o  (enter_dbg),
    .exit_dbg_o   (exit_dbg),
    .is_trap_o    (is_trap)
  );
  assign dbg_d    = (debug_mode_o | enter_dbg) & ~exit_dbg;
  // sleep wakes on any pending irq or debug request, but only a trap redirects out of it
  assign wake     = irq_pending_i | dbg_req_i;
  assign redirect = take & ((state_q != SLEEP) | (wake & is_trap));
  // single FSM register: state, flush counter and every output are updated together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RESET;
      cnt_q        <= '0;
      pc_sel_mux_o <= PC_BP;
      exc_sel_o    <= EXC_PC_EXC;
      pc_sel_o     <= 1'b0;
      pc_set_o     <= 1'b0;
      flush_o      <= 1'b1;
      debug_mode_o <= 1'b0;
      trap_ack_o   <= 1'b0;
    end else begin
      pc_sel_o   <= 1'b0;
      trap_ack_o <= 1'b0;
      case (state_q)
        RESET: begin
          state_q      <= BOOT;
          pc_sel_mux_o <= PC_BP;
          pc_set_o     <= 1'b0;
          flush_o      <= 1'b1;
        end
        BOOT: begin
          state_q      <= FETCH;
          pc_sel_mux_o <= PC_JUMP;
          pc_set_o     <= !stall_i;
          flush_o      <= 1'b0;
        end
        FLUSH: begin
          state_q      <= (cnt_q == 3'd1) ? (debug_mode_o ? DEBUG : FETCH) : FLUSH;
          cnt_q        <= cnt_q - 1'b1;
          pc_sel_mux_o <= PC_JUMP;
          pc_set_o     <= 1'b1;
          flush_o      <= 1'b1;
        end
        FETCH, DEBUG, SLEEP: begin
          if (redirect) begin
            state_q      <= (CntLoad == '0) ? (dbg_d ? DEBUG : FETCH) : FLUSH;
            cnt_q        <= CntLoad;
            pc_sel_mux_o <= mux;
            exc_sel_o    <= is_trap ? exc_sel : exc_sel_o;
            pc_sel_o     <= (mux == PC_JUMP);
            pc_set_o     <= 1'b0;
            flush_o      <= 1'b1;
            debug_mode_o <= dbg_d;
            trap_ack_o   <= is_trap;
          end else if ((state_q == SLEEP && !wake) || (state_q != SLEEP && wfi_i && !debug_mode_o)) begin
            // WFI is a no-op in debug mode so a halted core can never doze off
            state_q      <= SLEEP;
            pc_sel_mux_o <= PC_JUMP;
            pc_set_o     <= 1'b0;
            flush_o      <= 1'b0;
          end else begin
            state_q      <= debug_mode_o ? DEBUG : FETCH;
            pc_sel_mux_o <= PC_JUMP;
            pc_set_o     <= !stall_i;
            flush_o      <= 1'b0;
          end
        end
        default: begin
          state_q      <= RESET;
          cnt_q        <= '0;
          pc_sel_mux_o <= PC_BP;
          exc_sel_o    <= EXC_PC_EXC;
          pc_set_o     <= 1'b0;
          flush_o      <= 1'b1;
          debug_mode_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scenarios plus randomized run against a cycle-level event model
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic stall = 0, branch = 0, exc = 0, irq = 0, ien = 0, mret = 0, dret = 0, dbg = 0, wfi = 0;
  pc_sel_e     mux[2];
  exc_pc_sel_e esel[2];
  logic        psel[2], pset[2], fl_o[2], dm_o[2], tack[2];
  logic [9:0]  obs[2];
  logic [9:0]  ex[2];
  logic [9:0]  v;
  int          ph[2], fl[2], fc[2], nf[2];
  bit          dm[2], sl[2];
  exc_pc_sel_e es[2];
  int          n_cmp = 0, n_bad = 0;
  localparam logic [9:0] R = {PC_BP, EXC_PC_EXC, 5'b00100};
  always #5 clk = ~clk;
  assign obs[0] = {mux[0], esel[0], psel[0], pset[0], fl_o[0], dm_o[0], tack[0]};
  assign obs[1] = {mux[1], esel[1], psel[1], pset[1], fl_o[1], dm_o[1], tack[1]};
  if_fetch_ctrl #(.FLUSH_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_i(branch), .exc_i(exc),
    .irq_pending_i(irq), .irq_en_i(ien), .mret_i(mret), .dret_i(dret), .dbg_req_i(dbg), .wfi_i(wfi),
    .pc_sel_mux_o(mux[0]), .exc_sel_o(esel[0]), .pc_sel_o(psel[0]), .pc_set_o(pset[0]),
    .flush_o(fl_o[0]), .debug_mode_o(dm_o[0]), .trap_ack_o(tack[0])
  );
  if_fetch_ctrl #(.FLUSH_CYCLES(4)) u1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_i(branch), .exc_i(exc),
    .irq_pending_i(irq), .irq_en_i(ien), .mret_i(mret), .dret_i(dret), .dbg_req_i(dbg), .wfi_i(wfi),
    .pc_sel_mux_o(mux[1]), .exc_sel_o(esel[1]), .pc_sel_o(psel[1]), .pc_set_o(pset[1]),
    .flush_o(fl_o[1]), .debug_mode_o(dm_o[1]), .trap_ack_o(tack[1])
  );
  // reference: phase counter after reset, remaining flush cycles, sleep flag and debug flag
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      pc_sel_e m;
      bit ps, st, fo, ta;
      int e;
      m = PC_JUMP; ps = 0; st = 0; fo = 0; ta = 0;
      e = (dbg && !dm[k]) ? 1 : exc ? 2 : (irq && ien && !dm[k]) ? 3 : (dret && dm[k]) ? 4 :
          mret ? 5 : branch ? 6 : (wfi && !dm[k]) ? 7 : 0;
      if (!rst_n) begin
        ph[k] = 0; fl[k] = 0; dm[k] = 0; sl[k] = 0; es[k] = EXC_PC_EXC; m = PC_BP; fo = 1;
      end else if (ph[k] == 0) begin
        ph[k] = 1; m = PC_BP; fo = 1;
      end else if (ph[k] == 1) begin
        ph[k] = 2; st = !stall;
      end else if (fl[k] > 0) begin
        fl[k]--; st = 1; fo = 1;
      end else if (sl[k] && !(irq || dbg)) begin
        st = 0;
      end else if (sl[k] ? (e >= 1 && e <= 3) : (e >= 1 && e <= 6)) begin
        sl[k] = 0;
        m = (e <= 3) ? PC_EXC : (e == 4) ? PC_DRET : (e == 5) ? PC_ERET : PC_JUMP;
        ps = (e == 6); fo = 1; ta = (e <= 3);
        if (e == 1) begin es[k] = EXC_PC_DBD; dm[k] = 1; end
        if (e == 2) es[k] = dm[k] ? EXC_PC_DBG_EXC : EXC_PC_EXC;
        if (e == 3) es[k] = EXC_PC_IRQ;
        if (e == 4) dm[k] = 0;
        fl[k] = fc[k] - 1;
      end else if (!sl[k] && e == 7) begin
        sl[k] = 1;
      end else begin
        sl[k] = 0; st = !stall;
      end
      ex[k] = {m, es[k], ps, st, fo, dm[k], ta};
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== R) begin n_bad++; $display("FAIL reset dut%0d got %h expected %h", k, obs[k], R); end end
    rst_n = 1;
    tick();
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== R) begin n_bad++; $display("FAIL boot dut%0d got %h expected %h", k, obs[k], R); end end
    tick();
    v = {PC_JUMP, EXC_PC_EXC, 5'b01000};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL first_fetch dut%0d got %h expected %h", k, obs[k], v); end end
  endtask
  task automatic test_exc_branch();
    exc = 1; branch = 1;
    tick();
    exc = 0; branch = 0;
    v = {PC_EXC, EXC_PC_EXC, 5'b00101};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL exc_branch dut%0d got %h expected %h", k, obs[k], v); end end
    nf[0] = 1; nf[1] = 1;
    for (int c = 0; c < 7; c++) begin
      tick();
      for (int k = 0; k < 2; k++) if (fl_o[k]) nf[k]++;
    end
    for (int k = 0; k < 2; k++) begin n_cmp++; if (nf[k] !== fc[k]) begin n_bad++; $display("FAIL flush_len dut%0d got %0d expected %0d", k, nf[k], fc[k]); end end
  endtask
  task automatic test_sleep();
    irq = 1; ien = 0; wfi = 1;
    tick();
    wfi = 0;
    v = {PC_JUMP, EXC_PC_EXC, 5'b00000};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL sleep_enter dut%0d got %h expected %h", k, obs[k], v); end end
    tick();
    v = {PC_JUMP, EXC_PC_EXC, 5'b01000};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL sleep_wake_fetch dut%0d got %h expected %h", k, obs[k], v); end end
    irq = 0; wfi = 1;
    tick();
    wfi = 0;
    repeat (2) tick();
    v = {PC_JUMP, EXC_PC_EXC, 5'b00000};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL sleep_hold dut%0d got %h expected %h", k, obs[k], v); end end
    irq = 1; ien = 1;
    tick();
    irq = 0; ien = 0;
    v = {PC_EXC, EXC_PC_IRQ, 5'b00101};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL sleep_irq dut%0d got %h expected %h", k, obs[k], v); end end
    repeat (5) tick();
  endtask
  task automatic test_debug();
    dbg = 1;
    tick();
    v = {PC_EXC, EXC_PC_DBD, 5'b00111};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL dbg_entry dut%0d got %h expected %h", k, obs[k], v); end end
    repeat (5) tick();
    irq = 1; ien = 1;
    tick();
    v = {PC_JUMP, EXC_PC_DBD, 5'b01010};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL dbg_masks_irq dut%0d got %h expected %h", k, obs[k], v); end end
    exc = 1;
    tick();
    exc = 0;
    v = {PC_EXC, EXC_PC_DBG_EXC, 5'b00111};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL dbg_exc dut%0d got %h expected %h", k, obs[k], v); end end
    repeat (5) tick();
    dret = 1; dbg = 0; irq = 0; ien = 0;
    tick();
    dret = 0;
    v = {PC_DRET, EXC_PC_DBG_EXC, 5'b00100};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL dret dut%0d got %h expected %h", k, obs[k], v); end end
    repeat (5) tick();
    v = {PC_JUMP, EXC_PC_DBG_EXC, 5'b01000};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL dret_fetch dut%0d got %h expected %h", k, obs[k], v); end end
  endtask
  task automatic test_stall();
    stall = 1;
    v = {PC_JUMP, EXC_PC_DBG_EXC, 5'b00000};
    repeat (2) begin
      tick();
      for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL stall dut%0d got %h expected %h", k, obs[k], v); end end
    end
    branch = 1;
    tick();
    stall = 0; branch = 0;
    v = {PC_JUMP, EXC_PC_DBG_EXC, 5'b10100};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL stall_branch dut%0d got %h expected %h", k, obs[k], v); end end
    repeat (5) tick();
    v = {PC_JUMP, EXC_PC_DBG_EXC, 5'b01000};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL unstall dut%0d got %h expected %h", k, obs[k], v); end end
  endtask
  task automatic test_reset_in_flush();
    exc = 1;
    tick();
    exc = 0;
    tick();
    v = {PC_JUMP, EXC_PC_EXC, 5'b01100};
    n_cmp++; if (obs[1] !== v) begin n_bad++; $display("FAIL flush2 dut1 got %h expected %h", obs[1], v); end
    rst_n = 0;
    tick();
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== R) begin n_bad++; $display("FAIL mid_flush_reset dut%0d got %h expected %h", k, obs[k], R); end end
    rst_n = 1;
    tick();
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== R) begin n_bad++; $display("FAIL reboot dut%0d got %h expected %h", k, obs[k], R); end end
    tick();
    v = {PC_JUMP, EXC_PC_EXC, 5'b01000};
    for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== v) begin n_bad++; $display("FAIL refetch dut%0d got %h expected %h", k, obs[k], v); end end
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n  = ($urandom_range(0, 79) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      branch = ($urandom_range(0, 5) == 0);
      exc    = ($urandom_range(0, 9) == 0);
      mret   = ($urandom_range(0, 9) == 0);
      dret   = ($urandom_range(0, 5) == 0);
      wfi    = ($urandom_range(0, 7) == 0);
      ien    = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 7) == 0) irq = ~irq;
      if ($urandom_range(0, 11) == 0) dbg = ~dbg;
      tick();
      for (int k = 0; k < 2; k++) begin n_cmp++; if (obs[k] !== ex[k]) begin n_bad++; $display("FAIL random c%0d dut%0d got %h expected %h", c, k, obs[k], ex[k]); end end
    end
  endtask
  initial begin
    fc[0] = 2; fc[1] = 4;
    test_reset();
    test_exc_branch();
    test_sleep();
    test_debug();
    test_stall();
    test_reset_in_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
